interp_ram_responder: RTL and testbench

- Memory-side responder for the interpolation datapath's two-read/one-write RAM interface (ram_add1/ram_add2 -> ram_data1/ram_data2, mem_write + data_to_ram).
- Also provides a host burst-load port that fills the m constant, t table and u vectors before the interpolation module receives init_sg.
- Sits between the system host and InterpolationModule, and owns the word-addressed scratchpad.

---
 rtl/interp_ram_responder_pkg.sv | 30 +++
 rtl/interp_ram_responder_core.sv | 59 +++++
 rtl/interp_ram_responder.sv | 205 ++++++++++++++++++++
 tb/tb_interp_ram_responder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/interp_ram_responder_pkg.sv
// Shared definitions for the interpolation RAM responder: FSM state encoding,
// the fixed host-visible memory map and the default storage depth.
// Optional build macro: INTERP_RAM_CLEAR_EN adds the post-reset CLEAR state.
package interp_mem_pkg;

    // Default log2 of the implemented word count (1024 words)
    localparam int DEPTH_LOG2_DEF = 10;

    // Fixed memory map the host follows when preloading the interpolator
    localparam logic [15:0] M_CONST_ADD  = 16'h0000;
    localparam logic [15:0] T0_ADD       = 16'h0001;
    localparam logic [15:0] T1_ADD       = 16'h0002;
    localparam logic [15:0] U0_ADD       = 16'h0006;
    localparam logic [15:0] U_ADD_OFFSET = 16'h0200;

    // Responder FSM states; CLEAR only exists when the zeroing sweep is built in
`ifdef INTERP_RAM_CLEAR_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CLEAR = 2'd2
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1
    } state_e;
`endif

endpackage

// File: rtl/interp_ram_responder_core.sv
// 2-read / 1-write word store with registered read data and write-first
// bypass. Each read port can be forced to return zero (out-of-range address
// or memory being cleared); the decision is made by the caller.
module interp_ram_core
    import interp_mem_pkg::*;
#(
    parameter int WORD_SIZE  = 16,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_waddr,
    input  logic [WORD_SIZE-1:0]  i_wdata,
    input  logic [DEPTH_LOG2-1:0] i_raddr1,
    input  logic [DEPTH_LOG2-1:0] i_raddr2,
    input  logic                  i_zero1,
    input  logic                  i_zero2,
    output logic [WORD_SIZE-1:0]  o_rdata1,
    output logic [WORD_SIZE-1:0]  o_rdata2
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [WORD_SIZE-1:0] r_mem [DEPTH];
    logic [WORD_SIZE-1:0] r_rdata1;
    logic [WORD_SIZE-1:0] r_rdata2;

    logic w_hit1;
    logic w_hit2;

    assign w_hit1 = i_we && (i_waddr == i_raddr1);
    assign w_hit2 = i_we && (i_waddr == i_raddr2);

    // Storage write port
    // NOTE: the array has no reset so it maps onto block RAM; only the read
    // registers below are cleared.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered reads; a same-cycle write to the read address is forwarded
    // NOTE: state updates use <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata1 <= '0;
            r_rdata2 <= '0;
        end else begin
            r_rdata1 <= i_zero1 ? '0 : (w_hit1 ? i_wdata : r_mem[i_raddr1]);
            r_rdata2 <= i_zero2 ? '0 : (w_hit2 ? i_wdata : r_mem[i_raddr2]);
        end
    end

    assign o_rdata1 = r_rdata1;
    assign o_rdata2 = r_rdata2;

endmodule

// File: rtl/interp_ram_responder.sv
// Memory-side responder for the interpolation datapath. Serves two registered
// read ports and one write port to the interpolator, and a host burst-load
// port that preloads the m constant, t table and u vectors.
// Host writes win over interpolator writes during a burst; the dropped write
// is flagged on collision. Out-of-range accesses read zero, never write, and
// pulse addr_err.
// Optional build macro: INTERP_RAM_CLEAR_EN -- reset enters a CLEAR state that
// zeroes every word before the responder becomes idle.
module interp_ram_responder
    import interp_mem_pkg::*;
#(
    parameter int WORD_SIZE     = 16,
    parameter int ADDRESS_WIDTH = 16,
    parameter int DEPTH_LOG2    = DEPTH_LOG2_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] ram_add1,
    input  logic [ADDRESS_WIDTH-1:0] ram_add2,
    input  logic                     mem_write,
    input  logic [WORD_SIZE-1:0]     data_to_ram,
    output logic [WORD_SIZE-1:0]     ram_data1,
    output logic [WORD_SIZE-1:0]     ram_data2,
    input  logic                     host_start,
    input  logic [ADDRESS_WIDTH-1:0] host_base,
    input  logic [DEPTH_LOG2:0]      host_len,
    input  logic                     host_valid,
    input  logic [WORD_SIZE-1:0]     host_data,
    output logic                     host_ready,
    output logic                     load_done,
    output logic                     busy,
    output logic                     addr_err,
    output logic                     collision
);

    state_e                   r_state;
    logic [ADDRESS_WIDTH-1:0] r_ptr;
    logic [DEPTH_LOG2:0]      r_remaining;
`ifdef INTERP_RAM_CLEAR_EN
    logic [DEPTH_LOG2:0]      r_sweep;
`endif
    logic                     r_host_ready;
    logic                     r_load_done;
    logic                     r_busy;
    logic                     r_addr_err;
    logic                     r_collision;

    logic                     w_rd1_oor;
    logic                     w_rd2_oor;
    logic                     w_ptr_oor;
    logic [ADDRESS_WIDTH-1:0] w_ptr_next;
    logic                     w_host_wr;
    logic                     w_last_word;
    logic                     w_clearing;
    logic                     w_access_err;
    logic                     w_collision;
    logic                     w_we;
    logic [DEPTH_LOG2-1:0]    w_waddr;
    logic [WORD_SIZE-1:0]     w_wdata;

    // Range checks: a set upper address bit selects an unimplemented word
    assign w_rd1_oor = |ram_add1[ADDRESS_WIDTH-1:DEPTH_LOG2];
    assign w_rd2_oor = |ram_add2[ADDRESS_WIDTH-1:DEPTH_LOG2];
    assign w_ptr_oor = |r_ptr[ADDRESS_WIDTH-1:DEPTH_LOG2];

    assign w_host_wr   = (r_state == ST_LOAD) && host_valid;
    assign w_last_word = w_host_wr && (r_remaining == (DEPTH_LOG2+1)'(1));

`ifdef INTERP_RAM_CLEAR_EN
    assign w_clearing = (r_state == ST_CLEAR);
`else
    assign w_clearing = 1'b0;
`endif

    // Interpolator writes are only honoured while idle
    assign w_collision  = mem_write && (r_state != ST_IDLE);
    assign w_access_err = w_rd1_oor || w_rd2_oor || (w_host_wr && w_ptr_oor);

    // Burst pointer advance: in-range pointers wrap within the array, an
    // out-of-range pointer keeps counting so its words stay discarded
    // NOTE: every always_comb output gets a default first so no latch forms.
    always_comb begin
        w_ptr_next = r_ptr + ADDRESS_WIDTH'(1);
        if (!w_ptr_oor) begin
            w_ptr_next                   = '0;
            w_ptr_next[DEPTH_LOG2-1:0]   = r_ptr[DEPTH_LOG2-1:0] + DEPTH_LOG2'(1);
        end
    end

    // Write-port arbitration: one write source per state
    always_comb begin
        w_we    = 1'b0;
        w_waddr = ram_add1[DEPTH_LOG2-1:0];
        w_wdata = data_to_ram;
        case (r_state)
            ST_IDLE: begin
                w_we = mem_write && !w_rd1_oor;
            end
            ST_LOAD: begin
                w_we    = host_valid && !w_ptr_oor;
                w_waddr = r_ptr[DEPTH_LOG2-1:0];
                w_wdata = host_data;
            end
`ifdef INTERP_RAM_CLEAR_EN
            ST_CLEAR: begin
                w_we    = !r_sweep[DEPTH_LOG2];
                w_waddr = r_sweep[DEPTH_LOG2-1:0];
                w_wdata = '0;
            end
`endif
            default: begin
                w_we = 1'b0;
            end
        endcase
    end

    // Control FSM with pointer/counters and registered status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef INTERP_RAM_CLEAR_EN
            r_state <= ST_CLEAR;
            r_sweep <= '0;
`else
            r_state <= ST_IDLE;
`endif
            r_ptr        <= '0;
            r_remaining  <= '0;
            r_host_ready <= 1'b0;
            r_load_done  <= 1'b0;
            r_busy       <= 1'b0;
            r_addr_err   <= 1'b0;
            r_collision  <= 1'b0;
        end else begin
            r_load_done <= 1'b0;
            r_addr_err  <= w_access_err;
            r_collision <= w_collision;
            case (r_state)
                ST_IDLE: begin
                    if (host_start) begin
                        if (host_len == '0) begin
                            r_load_done <= 1'b1;
                        end else begin
                            r_state      <= ST_LOAD;
                            r_ptr        <= host_base;
                            r_remaining  <= host_len;
                            r_host_ready <= 1'b1;
                            r_busy       <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (host_valid) begin
                        r_ptr       <= w_ptr_next;
                        r_remaining <= r_remaining - (DEPTH_LOG2+1)'(1);
                        if (w_last_word) begin
                            r_state      <= ST_IDLE;
                            r_host_ready <= 1'b0;
                            r_busy       <= 1'b0;
                            r_load_done  <= 1'b1;
                        end
                    end
                end
`ifdef INTERP_RAM_CLEAR_EN
                ST_CLEAR: begin
                    if (r_sweep[DEPTH_LOG2]) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_sweep <= '0;
                    end else begin
                        r_busy  <= 1'b1;
                        r_sweep <= r_sweep + (DEPTH_LOG2+1)'(1);
                    end
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    interp_ram_core #(
        .WORD_SIZE  (WORD_SIZE),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .i_we     (w_we),
        .i_waddr  (w_waddr),
        .i_wdata  (w_wdata),
        .i_raddr1 (ram_add1[DEPTH_LOG2-1:0]),
        .i_raddr2 (ram_add2[DEPTH_LOG2-1:0]),
        .i_zero1  (w_rd1_oor || w_clearing),
        .i_zero2  (w_rd2_oor || w_clearing),
        .o_rdata1 (ram_data1),
        .o_rdata2 (ram_data2)
    );

    assign host_ready = r_host_ready;
    assign load_done  = r_load_done;
    assign busy       = r_busy;
    assign addr_err   = r_addr_err;
    assign collision  = r_collision;

endmodule

// File: tb/tb_interp_ram_responder.sv
// Directed bench for interp_ram_responder: burst load, write-first bypass,
// collision drop, range errors, pointer wrap, stall and mid-burst reset.
// Read expectations come from a bench-side memory model via a scoreboard.
module tb_interp_ram_responder;
    import interp_mem_pkg::*;

    localparam int DL    = 10;
    localparam int DEPTH = 1 << DL;
    localparam logic [15:0] U0_ABS = U_ADD_OFFSET + U0_ADD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] ram_add1 = '0;
    logic [15:0] ram_add2 = '0;
    logic        mem_write = 1'b0;
    logic [15:0] data_to_ram = '0;
    logic [15:0] ram_data1;
    logic [15:0] ram_data2;
    logic        host_start = 1'b0;
    logic [15:0] host_base = '0;
    logic [DL:0] host_len = '0;
    logic        host_valid = 1'b0;
    logic [15:0] host_data = '0;
    logic        host_ready;
    logic        load_done;
    logic        busy;
    logic        addr_err;
    logic        collision;

    typedef struct {
        logic [15:0] d1;
        logic [15:0] d2;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] model [0:DEPTH-1];
    int          checks = 0;
    int          errors = 0;

    interp_ram_responder dut (
        .clk         (clk),
        .rst         (rst),
        .ram_add1    (ram_add1),
        .ram_add2    (ram_add2),
        .mem_write   (mem_write),
        .data_to_ram (data_to_ram),
        .ram_data1   (ram_data1),
        .ram_data2   (ram_data2),
        .host_start  (host_start),
        .host_base   (host_base),
        .host_len    (host_len),
        .host_valid  (host_valid),
        .host_data   (host_data),
        .host_ready  (host_ready),
        .load_done   (load_done),
        .busy        (busy),
        .addr_err    (addr_err),
        .collision   (collision)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_rd(input logic [15:0] a);
        logic [DL-1:0] idx;
        idx = a[DL-1:0];
        return (a >= 16'(DEPTH)) ? 16'h0000 : model[idx];
    endfunction

    // Read both ports; expectation queued at issue, compared when data appears
    task automatic rd(input logic [15:0] a1, input logic [15:0] a2);
        exp_t e;
        e.d1 = model_rd(a1);
        e.d2 = model_rd(a2);
        sb.push_back(e);
        ram_add1  = a1;
        ram_add2  = a2;
        mem_write = 1'b0;
        tick();
        e = sb.pop_front();
        check("rd_port1", 32'(ram_data1), 32'(e.d1));
        check("rd_port2", 32'(ram_data2), 32'(e.d2));
    endtask

    // Idle write with both ports reading the written word (write-first)
    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        exp_t e;
        logic [DL-1:0] idx;
        idx = a[DL-1:0];
        if (a < 16'(DEPTH)) model[idx] = d;
        e.d1 = model_rd(a);
        e.d2 = model_rd(a);
        sb.push_back(e);
        ram_add1    = a;
        ram_add2    = a;
        data_to_ram = d;
        mem_write   = 1'b1;
        tick();
        mem_write = 1'b0;
        e = sb.pop_front();
        check("wf_port1", 32'(ram_data1), 32'(e.d1));
        check("wf_port2", 32'(ram_data2), 32'(e.d2));
    endtask

    task automatic start_burst(input logic [15:0] base, input logic [DL:0] len);
        host_base  = base;
        host_len   = len;
        host_start = 1'b1;
        tick();
        host_start = 1'b0;
    endtask

    initial begin
        int n;

        // Reset state
        tick();
        tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_ready", 32'(host_ready), 0);
        check("rst_done", 32'(load_done), 0);
        check("rst_addr_err", 32'(addr_err), 0);
        check("rst_collision", 32'(collision), 0);
        check("rst_data1", 32'(ram_data1), 0);
        check("rst_data2", 32'(ram_data2), 0);
        rst = 1'b0;

`ifdef INTERP_RAM_CLEAR_EN
        n = 0;
        for (int i = 0; i < 1100; i++) begin
            tick();
            if (busy) n++;
        end
        check("clear_busy_cycles", 32'(n), 1024);
        for (int i = 0; i < DEPTH; i++) model[i] = 16'h0000;
        rd(16'h0123, 16'h03FF);
`endif

        // Burst load of t0/t1
        start_burst(T0_ADD, 2);
        check("burst_busy", 32'(busy), 1);
        check("burst_ready_w1", 32'(host_ready), 1);
        host_valid = 1'b1;
        host_data  = 16'h0080;
        tick();
        check("burst_ready_w2", 32'(host_ready), 1);
        check("burst_done_early", 32'(load_done), 0);
        host_data = 16'h0100;
        tick();
        host_valid = 1'b0;
        check("burst_done", 32'(load_done), 1);
        check("burst_ready_drop", 32'(host_ready), 0);
        check("burst_idle", 32'(busy), 0);
        tick();
        check("burst_done_pulse", 32'(load_done), 0);
        model[1] = 16'h0080;
        model[2] = 16'h0100;
        rd(T0_ADD, T1_ADD);

        // Write-first into the u vector
        wr(U0_ABS, 16'h1234);

        // Interpolator write dropped during a burst
        wr(16'h0005, 16'hBEEF);
        start_burst(16'h0010, 1);
        ram_add1    = 16'h0005;
        ram_add2    = 16'h0005;
        data_to_ram = 16'hDEAD;
        mem_write   = 1'b1;
        tick();
        mem_write = 1'b0;
        check("collision_pulse", 32'(collision), 1);
        tick();
        check("collision_clear", 32'(collision), 0);
        host_valid = 1'b1;
        host_data  = 16'h5555;
        tick();
        host_valid = 1'b0;
        check("collision_burst_done", 32'(load_done), 1);
        model[16'h0010] = 16'h5555;
        rd(16'h0005, 16'h0010);

        // Range checks
        wr(M_CONST_ADD, 16'h0A0A);
        rd(16'h0001, 16'h0400);
        check("oor_rd_err", 32'(addr_err), 1);
        rd(16'h0001, 16'h0002);
        check("oor_rd_err_1cyc", 32'(addr_err), 0);
        wr(16'h0400, 16'hFFFF);
        check("oor_wr_err", 32'(addr_err), 1);
        rd(16'h0000, 16'h0000);
        check("oor_wr_err_1cyc", 32'(addr_err), 0);

        // Zero-length burst
        start_burst(16'h0030, 0);
        check("len0_done", 32'(load_done), 1);
        check("len0_idle", 32'(busy), 0);
        tick();
        check("len0_done_pulse", 32'(load_done), 0);

        // Pointer wrap at the top of the array
        start_burst(16'h03FF, 2);
        host_valid = 1'b1;
        host_data  = 16'hA1A1;
        tick();
        host_data = 16'hB2B2;
        tick();
        host_valid = 1'b0;
        check("wrap_done", 32'(load_done), 1);
        model[16'h03FF] = 16'hA1A1;
        model[16'h0000] = 16'hB2B2;
        rd(16'h03FF, 16'h0000);

        // Burst starting out of range: word discarded, not wrapped
        start_burst(16'h0400, 1);
        host_valid = 1'b1;
        host_data  = 16'hC3C3;
        tick();
        host_valid = 1'b0;
        check("oor_burst_err", 32'(addr_err), 1);
        check("oor_burst_done", 32'(load_done), 1);
        rd(16'h0000, 16'h0000);

        // Stall for four cycles, then reset mid-burst
        start_burst(16'h0020, 3);
        host_valid = 1'b1;
        host_data  = 16'h7777;
        tick();
        host_valid = 1'b0;
        model[16'h0020] = 16'h7777;
        for (int i = 0; i < 4; i++) begin
            host_start = (i == 1);
            host_len   = '0;
            tick();
            check("stall_busy", 32'(busy), 1);
            check("stall_ready", 32'(host_ready), 1);
            check("stall_no_done", 32'(load_done), 0);
        end
        host_start = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_ready", 32'(host_ready), 0);
`ifdef INTERP_RAM_CLEAR_EN
        for (int i = 0; i < 1030; i++) tick();
        check("clear2_idle", 32'(busy), 0);
        for (int i = 0; i < DEPTH; i++) model[i] = 16'h0000;
`endif
        rd(16'h0020, 16'h0020);

        check("scoreboard_empty", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
